// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned N_DEF = 8;
   localparam int unsigned M_DEF = 4;

   // Iteration counter must be able to hold 0..N.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int unsigned M = 4
) (
   input  logic [M-1:0] r_i,
   input  logic         bit_i,
   input  logic [M-1:0] divisor_i,
   output logic [M-1:0] r_nxt_c_o,
   output logic         q_bit_c_o
);

   logic [M:0] r_shift;
   logic [M:0] r_sub;

   // The partial remainder stays below the divisor, so the dropped MSB never carries information.
   always_comb begin
      r_shift   = {r_i, bit_i};
      r_sub     = r_shift - (M+1)'(divisor_i);
      q_bit_c_o = (r_shift >= {1'b0, divisor_i});
      r_nxt_c_o = q_bit_c_o ? M'(r_sub) : M'(r_shift);
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional `DIV_ZERO_FAST_EN short-circuits a zero divisor straight to the result.
module seq_restoring_divider
   import seq_div_pkg::*;
#(
   parameter int unsigned N = N_DEF,
   parameter int unsigned M = M_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [M-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [M-1:0] remainder,
   output logic         div_zero
);

   localparam int unsigned CW = cnt_w(N);

   state_e        state_q, state_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [M-1:0]  dvs_q, dvs_d;
   logic [M-1:0]  rem_q, rem_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dz_q, dz_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic [M-1:0]  step_r_c;
   logic          step_q_c;
   logic          fast_skip_c;
   logic          fast_load_c;

   div_step #(.M(M)) u_step (
      .r_i       (rem_q),
      .bit_i     (dvd_q[N-1]),
      .divisor_i (dvs_q),
      .r_nxt_c_o (step_r_c),
      .q_bit_c_o (step_q_c)
   );

`ifdef DIV_ZERO_FAST_EN
   assign fast_skip_c = dz_q;
   assign fast_load_c = (divisor == '0);
`else
   assign fast_skip_c = 1'b0;
   assign fast_load_c = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         dz_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         dz_q        <= dz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               rem_d   = '0;
               quo_d   = '0;
               cnt_d   = '0;
               dz_d    = (divisor == '0);
               state_d = CALC;
               // Zero-divisor result is known up front; CALC then just hands off to DONE.
               if (fast_load_c) begin
                  quo_d = '1;
                  rem_d = dividend[M-1:0];
               end
            end
         end
         CALC: begin
            if (fast_skip_c) begin
               state_d = DONE;
            end else begin
               dvd_d = dvd_q << 1;
               rem_d = step_r_c;
               quo_d = N'({quo_q, step_q_c});
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule
